// File: rtl/ocrom_loader_if.sv
// Stream-in and Avalon-MM master bundle for ocrom_loader.
// master = the loader side, slave = word source plus on-chip memory.
interface ocrom_loader_if #(
   parameter int ADDR_W = 10
);
   logic [31:0]       in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_chipselect;
   logic              avm_write;
   logic [31:0]       avm_writedata;
   logic [3:0]        avm_byteenable;
   logic              avm_debugaccess;
   logic              avm_clken;
   logic [31:0]       avm_readdata;

   modport master (
      input  in_data, in_valid, avm_readdata,
      output in_ready, avm_address, avm_chipselect, avm_write,
             avm_writedata, avm_byteenable, avm_debugaccess, avm_clken
   );

   modport slave (
      output in_data, in_valid, avm_readdata,
      input  in_ready, avm_address, avm_chipselect, avm_write,
             avm_writedata, avm_byteenable, avm_debugaccess, avm_clken
   );
endinterface

// File: rtl/ocrom_loader.sv
// Fills the Nios II on-chip instruction memory from a word stream, one debug write per cycle.
// Define OCROM_LOADER_VERIFY_EN to add the read-back pass with additive checksum.
//
// Handshake: a stream word transfers in every cycle where in_valid and in_ready are both 1
// at the rising edge; in_ready depends on state only and never on in_valid.
module ocrom_loader #(
   parameter int ADDR_W = 10,
   parameter int WORDS  = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic [ADDR_W:0]   length_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [2:0]        dbg_state_o,
   ocrom_loader_if.master    bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_RD    = 3'd2,
      S_CAP   = 3'd3,
      S_FIN   = 3'd4
   } state_e;

   localparam logic [ADDR_W:0] WORDS_L = (ADDR_W+1)'(WORDS);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              busy_q, done_q;
   logic [ADDR_W:0]   len_clamped;

   logic              in_ready;
   logic              cs;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;

`ifdef OCROM_LOADER_VERIFY_EN
   logic [31:0]       sum_q, sum_d;
   logic              error_q, error_d;
   logic              rd_pend_q;
`endif

   assign len_clamped = (length_i > WORDS_L) ? WORDS_L : length_i;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      in_ready = 1'b0;
      cs       = 1'b0;
      wr       = 1'b0;
      addr     = '0;
      wdata    = '0;
`ifdef OCROM_LOADER_VERIFY_EN
      sum_d    = sum_q;
      error_d  = error_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               len_d = len_clamped;
               cnt_d = '0;
`ifdef OCROM_LOADER_VERIFY_EN
               sum_d   = '0;
               error_d = 1'b0;
`endif
               state_d = (len_clamped == '0) ? S_FIN : S_WRITE;
            end
         end
         S_WRITE: begin
            in_ready = 1'b1;
            // Strobes follow in_valid in the same cycle so each word lands as it is offered.
            if (bus.in_valid) begin
               cs    = 1'b1;
               wr    = 1'b1;
               addr  = cnt_q[ADDR_W-1:0];
               wdata = bus.in_data;
               cnt_d = cnt_q + 1'b1;
`ifdef OCROM_LOADER_VERIFY_EN
               sum_d = sum_q + bus.in_data;
`endif
               if (cnt_q == len_q - 1'b1) begin
`ifdef OCROM_LOADER_VERIFY_EN
                  state_d = S_RD;
                  cnt_d   = '0;
`else
                  state_d = S_FIN;
`endif
               end
            end
         end
         S_RD: begin
            cs    = 1'b1;
            addr  = cnt_q[ADDR_W-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) begin
               state_d = S_CAP;
            end
         end
         S_CAP: begin
            state_d = S_FIN;
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
`ifdef OCROM_LOADER_VERIFY_EN
      // Read data returns one cycle after its address; rd_pend_q marks that cycle.
      if (rd_pend_q) begin
         sum_d = sum_d - bus.avm_readdata;
      end
      if (state_d == S_FIN) begin
         error_d = (sum_d != 32'd0);
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         busy_q  <= (state_d == S_WRITE) || (state_d == S_RD) || (state_d == S_CAP);
         done_q  <= (state_d == S_FIN);
      end
   end

`ifdef OCROM_LOADER_VERIFY_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q     <= '0;
         error_q   <= 1'b0;
         rd_pend_q <= 1'b0;
      end else begin
         sum_q     <= sum_d;
         error_q   <= error_d;
         rd_pend_q <= (state_q == S_RD);
      end
   end

   assign error_o = error_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^bus.avm_readdata;
   assign error_o      = 1'b0;
`endif

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign dbg_state_o = state_q;

   assign bus.in_ready        = in_ready;
   assign bus.avm_chipselect  = cs;
   assign bus.avm_write       = wr;
   assign bus.avm_debugaccess = wr;
   assign bus.avm_address     = addr;
   assign bus.avm_writedata   = wdata;
   assign bus.avm_byteenable  = 4'hF;
   assign bus.avm_clken       = 1'b1;

endmodule
